// File: rtl/pe_array_feeder.sv
// Operand streamer for an N x N systolic MAC array: buffers a K-term operand set,
// then replays it gap-free with per-lane diagonal skew and row-aligned cal_en/cal_done.
module pe_array_feeder #(
  parameter int N      = 4,
  parameter int IN_LEN = 8,
  parameter int K_MAX  = 16,
  parameter int KW     = $clog2(K_MAX + 1)
) (
  input  logic                clk,
  input  logic                sys_rst,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                vec_valid,
  output logic                vec_ready,
  input  logic [N*IN_LEN-1:0] a_vec,
  input  logic [N*IN_LEN-1:0] b_vec,
  output logic [N*IN_LEN-1:0] west_data,
  output logic [N*IN_LEN-1:0] north_data,
  output logic [N-1:0]        row_cal_en,
  output logic [N-1:0]        row_cal_done
);

  localparam int DW = N * IN_LEN;
  localparam int AW = (K_MAX > 1) ? $clog2(K_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_FLUSH
  } state_t;

  state_t          state, state_nx;
  logic [KW-1:0]   cnt, cnt_nx;
  logic [KW-1:0]   klen_q, klen_nx;
  logic            done_nx, err_nx;
  logic            klen_legal;
  logic            beat;

  logic            feed_v, feed_l;
  logic [DW-1:0]   feed_a, feed_b;

  logic [2*DW-1:0] mem [K_MAX];
  logic [2*DW-1:0] rd_word, head_word;

  assign klen_legal = (k_len != '0) && (k_len <= KW'(K_MAX));
  assign beat       = vec_valid && vec_ready;
  assign rd_word    = mem[cnt[AW-1:0]];
  assign head_word  = mem[0];

  always_ff @(posedge clk) begin
    if (beat) begin
      mem[cnt[AW-1:0]] <= {a_vec, b_vec};
    end
  end

  // The first stream entry is issued on the same edge that accepts the last beat;
  // for a one-term job that entry is still on the input bus, so it is bypassed.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    klen_nx  = klen_q;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    feed_v   = 1'b0;
    feed_l   = 1'b0;
    feed_a   = '0;
    feed_b   = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (klen_legal) begin
            klen_nx  = k_len;
            cnt_nx   = '0;
            state_nx = S_LOAD;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (beat) begin
          cnt_nx = cnt + KW'(1);
          if (cnt == klen_q - KW'(1)) begin
            state_nx = S_STREAM;
            cnt_nx   = KW'(1);
            feed_v   = 1'b1;
            feed_l   = (klen_q == KW'(1));
            if (cnt == '0) begin
              feed_a = a_vec;
              feed_b = b_vec;
            end else begin
              feed_a = head_word[2*DW-1:DW];
              feed_b = head_word[DW-1:0];
            end
          end
        end
      end
      S_STREAM: begin
        if (cnt == klen_q) begin
          cnt_nx   = '0;
          state_nx = (N > 1) ? S_FLUSH : S_IDLE;
          done_nx  = (N == 1);
        end else begin
          cnt_nx = cnt + KW'(1);
          feed_v = 1'b1;
          feed_l = (cnt == klen_q - KW'(1));
          feed_a = rd_word[2*DW-1:DW];
          feed_b = rd_word[DW-1:0];
        end
      end
      S_FLUSH: begin
        cnt_nx = cnt + KW'(1);
        if (cnt == KW'(N - 2)) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      klen_q    <= '0;
      busy      <= 1'b0;
      vec_ready <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      klen_q    <= klen_nx;
      busy      <= (state_nx != S_IDLE);
      vec_ready <= (state_nx == S_LOAD);
      done      <= done_nx;
      err       <= err_nx;
    end
  end

  // Row i: head register plus i delay stages; cal_en/cal_done ride along.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    logic [(gi+1)*IN_LEN-1:0] a_sr;
    logic [gi:0]              en_sr;
    logic [gi:0]              dn_sr;

    if (gi == 0) begin : g_head
      always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
          a_sr  <= '0;
          en_sr <= '0;
          dn_sr <= '0;
        end else begin
          a_sr  <= feed_a[gi*IN_LEN +: IN_LEN];
          en_sr <= feed_v;
          dn_sr <= feed_l;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
          a_sr  <= '0;
          en_sr <= '0;
          dn_sr <= '0;
        end else begin
          a_sr  <= {a_sr[gi*IN_LEN-1:0], feed_a[gi*IN_LEN +: IN_LEN]};
          en_sr <= {en_sr[gi-1:0], feed_v};
          dn_sr <= {dn_sr[gi-1:0], feed_l};
        end
      end
    end

    assign west_data[gi*IN_LEN +: IN_LEN] = a_sr[gi*IN_LEN +: IN_LEN];
    assign row_cal_en[gi]                 = en_sr[gi];
    assign row_cal_done[gi]               = dn_sr[gi];
  end

  for (genvar gj = 0; gj < N; gj++) begin : g_col
    logic [(gj+1)*IN_LEN-1:0] b_sr;

    if (gj == 0) begin : g_head
      always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
          b_sr <= '0;
        end else begin
          b_sr <= feed_b[gj*IN_LEN +: IN_LEN];
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
          b_sr <= '0;
        end else begin
          b_sr <= {b_sr[gj*IN_LEN-1:0], feed_b[gj*IN_LEN +: IN_LEN]};
        end
      end
    end

    assign north_data[gj*IN_LEN +: IN_LEN] = b_sr[gj*IN_LEN +: IN_LEN];
  end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Self-checking bench for pe_array_feeder: randomized jobs compared against a
// cycle-indexed reference of the skewed output schedule.
module tb_pe_array_feeder;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int K_MAX = 16;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int DW    = N * W;
  localparam int NJ    = 8;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          busy, done, err;
  logic          vec_valid, vec_ready;
  logic [DW-1:0] a_vec, b_vec;
  logic [DW-1:0] west_data, north_data;
  logic [N-1:0]  row_cal_en, row_cal_done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] ma [K_MAX][N];
  logic [W-1:0] mb [K_MAX][N];

  typedef struct {
    int k;
    int stall_at;
    int stall_len;
    bit rnd;
    bit ign;
    bit chain;
  } job_t;

  job_t jobs [NJ];
  int   ks   [NJ];

  pe_array_feeder #(.N(N), .IN_LEN(W), .K_MAX(K_MAX), .KW(KW)) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .k_len        (k_len),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .vec_valid    (vec_valid),
    .vec_ready    (vec_ready),
    .a_vec        (a_vec),
    .b_vec        (b_vec),
    .west_data    (west_data),
    .north_data   (north_data),
    .row_cal_en   (row_cal_en),
    .row_cal_done (row_cal_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int s);
    for (int i = 0; i < N; i++) begin
      a_vec[i*W +: W] = ma[s][i];
      b_vec[i*W +: W] = mb[s][i];
    end
  endtask

  task automatic test_reset();
    logic [3*N+4-1:0] ctl;
    sys_rst = 1'b1; start = 1'b0; k_len = '0; vec_valid = 1'b0;
    a_vec = '0; b_vec = '0;
    step(); step();
    ctl = {busy, done, err, vec_ready, row_cal_en, row_cal_done, {N{1'b0}}};
    checks++;
    if (ctl !== '0) begin
      errors++; $display("FAIL por_ctl got %h want 0", ctl);
    end
    checks++;
    if ({west_data, north_data} !== '0) begin
      errors++; $display("FAIL por_data got %h want 0", {west_data, north_data});
    end
    sys_rst = 1'b0;
    step();
    checks++;
    if ({busy, vec_ready, done, err} !== 4'b0) begin
      errors++; $display("FAIL idle_after_por got %b want 0000", {busy, vec_ready, done, err});
    end

    // mid-stream abort
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < N; i++) begin
        ma[s][i] = W'($urandom_range(1, 255));
        mb[s][i] = W'($urandom_range(1, 255));
      end
    start = 1'b1; k_len = KW'(4);
    step();
    start = 1'b0;
    for (int s = 0; s < 4; s++) begin
      vec_valid = 1'b1; drive_beat(s);
      step();
    end
    vec_valid = 1'b0;
    step();
    checks++;
    if (row_cal_en !== 4'b0011) begin
      errors++; $display("FAIL pre_abort_cal_en got %b want 0011", row_cal_en);
    end
    checks++;
    if (west_data[W-1:0] !== ma[1][0]) begin
      errors++; $display("FAIL pre_abort_west0 got %h want %h", west_data[W-1:0], ma[1][0]);
    end
    sys_rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, vec_ready, row_cal_en, row_cal_done} !== '0) begin
      errors++; $display("FAIL abort_ctl got %b want 0",
                         {busy, done, err, vec_ready, row_cal_en, row_cal_done});
    end
    checks++;
    if ({west_data, north_data} !== '0) begin
      errors++; $display("FAIL abort_data got %h want 0", {west_data, north_data});
    end
    step(); step(); step();
    sys_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if ({busy, vec_ready, done, row_cal_en} !== '0 || west_data !== '0 || north_data !== '0) begin
        errors++; $display("FAIL after_abort c=%0d got busy=%b rdy=%b done=%b en=%b west=%h north=%h want all 0",
                           c, busy, vec_ready, done, row_cal_en, west_data, north_data);
      end
    end
  endtask

  task automatic test_err();
    int bad [3];
    bad[0] = 0; bad[1] = K_MAX + 1; bad[2] = (1 << KW) - 1;
    for (int n = 0; n < 3; n++) begin
      step();
      start = 1'b1; k_len = KW'(bad[n]);
      step();
      start = 1'b0;
      checks++;
      if ({err, busy, vec_ready} !== 3'b100) begin
        errors++; $display("FAIL err_pulse k=%0d got err/busy/rdy=%b want 100", bad[n], {err, busy, vec_ready});
      end
      step();
      checks++;
      if ({err, busy, vec_ready} !== 3'b000) begin
        errors++; $display("FAIL err_clear k=%0d got err/busy/rdy=%b want 000", bad[n], {err, busy, vec_ready});
      end
    end
  endtask

  task automatic test_jobs();
    bit            pre;
    int            k, t_end;
    logic [DW-1:0] ew, en;
    logic [N-1:0]  ece, ecd;
    jobs[0] = '{3,  99, 0, 1'b0, 1'b0, 1'b0};
    jobs[1] = '{3,  2,  5, 1'b0, 1'b0, 1'b0};
    jobs[2] = '{1,  99, 0, 1'b0, 1'b0, 1'b0};
    jobs[3] = '{16, 5,  2, 1'b1, 1'b0, 1'b0};
    jobs[4] = '{5,  99, 0, 1'b1, 1'b1, 1'b1};
    jobs[5] = '{7,  3,  1, 1'b1, 1'b0, 1'b1};
    jobs[6] = '{2,  99, 0, 1'b1, 1'b1, 1'b0};
    jobs[7] = '{0,  1,  3, 1'b1, 1'b0, 1'b0};
    for (int e = 0; e < NJ; e++)
      ks[e] = (jobs[e].k == 0) ? int'($urandom_range(1, K_MAX)) : jobs[e].k;

    pre = 1'b0;
    for (int e = 0; e < NJ; e++) begin
      k = ks[e];
      for (int s = 0; s < k; s++)
        for (int i = 0; i < N; i++) begin
          ma[s][i] = jobs[e].rnd ? W'($urandom) : W'(16 * s + i);
          mb[s][i] = jobs[e].rnd ? W'($urandom) : W'(8'h80 + 16 * s + i);
        end
      if (!pre) begin
        step();
        start = 1'b1; k_len = KW'(k);
      end
      step();
      start = 1'b0;

      for (int b = 0; b < k; b++) begin
        if (b == jobs[e].stall_at) begin
          for (int t = 0; t < jobs[e].stall_len; t++) begin
            vec_valid = 1'b0; a_vec = $urandom; b_vec = $urandom;
            checks++;
            if ({vec_ready, busy, done} !== 3'b110) begin
              errors++; $display("FAIL stall_ready job=%0d got rdy/busy/done=%b want 110", e, {vec_ready, busy, done});
            end
            step();
          end
        end
        vec_valid = 1'b1; drive_beat(b);
        checks++;
        if ({vec_ready, busy, done} !== 3'b110) begin
          errors++; $display("FAIL load_ready job=%0d beat=%0d got rdy/busy/done=%b want 110", e, b, {vec_ready, busy, done});
        end
        step();
      end
      vec_valid = 1'b0; a_vec = $urandom; b_vec = $urandom;

      // now in T0; c counts cycles after T0
      t_end = k + N - 1;
      for (int c = 0; c <= t_end; c++) begin
        ew = '0; en = '0; ece = '0; ecd = '0;
        for (int i = 0; i < N; i++) begin
          int s;
          s = c - i;
          if (s >= 0 && s < k) begin
            ew[i*W +: W] = ma[s][i];
            en[i*W +: W] = mb[s][i];
            ece[i]       = 1'b1;
            ecd[i]       = (s == k - 1);
          end
        end
        checks++;
        if (west_data !== ew) begin
          errors++; $display("FAIL west job=%0d T0+%0d got %h want %h", e, c, west_data, ew);
        end
        checks++;
        if (north_data !== en) begin
          errors++; $display("FAIL north job=%0d T0+%0d got %h want %h", e, c, north_data, en);
        end
        checks++;
        if (row_cal_en !== ece) begin
          errors++; $display("FAIL cal_en job=%0d T0+%0d got %b want %b", e, c, row_cal_en, ece);
        end
        checks++;
        if (row_cal_done !== ecd) begin
          errors++; $display("FAIL cal_done job=%0d T0+%0d got %b want %b", e, c, row_cal_done, ecd);
        end
        checks++;
        if (busy !== (c < t_end)) begin
          errors++; $display("FAIL busy job=%0d T0+%0d got %b want %b", e, c, busy, (c < t_end));
        end
        checks++;
        if (done !== (c == t_end)) begin
          errors++; $display("FAIL done job=%0d T0+%0d got %b want %b", e, c, done, (c == t_end));
        end
        checks++;
        if ({vec_ready, err} !== 2'b00) begin
          errors++; $display("FAIL rdy_err job=%0d T0+%0d got %b want 00", e, c, {vec_ready, err});
        end
        if (jobs[e].ign && c == 1) begin
          start = 1'b1; k_len = KW'(2);
        end else if (c == t_end && jobs[e].chain) begin
          start = 1'b1; k_len = KW'(ks[e + 1]);
        end else begin
          start = 1'b0;
        end
        if (c < t_end) step();
      end

      pre = jobs[e].chain;
      if (!pre) begin
        step();
        checks++;
        if ({busy, vec_ready, done, row_cal_en} !== '0 || west_data !== '0) begin
          errors++; $display("FAIL post_job job=%0d got busy=%b rdy=%b done=%b en=%b west=%h want all 0",
                             e, busy, vec_ready, done, row_cal_en, west_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_err();
    test_jobs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
